// File: rtl/fetch_align_buffer.sv
`default_nettype none
// ============================================================================
// fetch_align_buffer: parcel realignment buffer between fetch and decode.
// Optional counters: define FETCH_ALIGN_STATS_EN.       Revision: 1.0
// ============================================================================
module fetch_align_buffer #(
    parameter int                FETCH_W  = 32,
    parameter int                DEPTH    = 8,
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush_i,
    input  logic [ADDR_W-1:0]  flush_pc_i,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FETCH_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               out_compressed
`ifdef FETCH_ALIGN_STATS_EN
    ,
    output logic [31:0]        stat_rvc_cnt,
    output logic [31:0]        stat_rvi_cnt,
    output logic [31:0]        stat_stall_cnt
`endif
);

    localparam int c_parcels = FETCH_W / 16;
    localparam int c_ptr_w   = $clog2(DEPTH);
    localparam int c_cnt_w   = c_ptr_w + 1;
    localparam int c_off_w   = (c_parcels > 1) ? $clog2(c_parcels) : 1;
    localparam logic [c_cnt_w-1:0] c_depth     = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_parcels_w = c_cnt_w'(c_parcels);

    logic [15:0]         mem_q [DEPTH];
    logic [15:0]         mem_d [DEPTH];
    logic [c_ptr_w-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_ptr_p1;
    logic [c_cnt_w-1:0]  count_q, count_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [c_off_w-1:0]  flush_off_q, flush_off_d, flush_off_in;
    logic                skip_pending_q, skip_pending_d;

    logic [15:0]         p0, p1;
    logic                is32, accept, handshake;
    logic [c_cnt_w-1:0]  skip, written, consumed;

    // Only the parcel offset of a redirect target is needed once out_pc is loaded.
    generate
        if (c_parcels > 1) begin : g_off
            assign flush_off_in = flush_pc_i[c_off_w:1];
        end else begin : g_no_off
            assign flush_off_in = '0;
        end
    endgenerate

    assign rd_ptr_p1 = rd_ptr_q + c_ptr_w'(1);
    assign p0        = mem_q[rd_ptr_q];
    assign p1        = mem_q[rd_ptr_p1];
    assign is32      = (p0[1:0] == 2'b11);
    assign out_pc    = pc_q;

    always_comb begin
        mem_d          = mem_q;
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        count_d        = count_q;
        pc_d           = pc_q;
        flush_off_d    = flush_off_q;
        skip_pending_d = skip_pending_q;

        in_ready       = !flush_i && ((c_depth - count_q) >= c_parcels_w);
        out_valid      = is32 ? (count_q >= c_cnt_w'(2)) : (count_q != '0);
        out_instr      = '0;
        out_compressed = 1'b0;
        if (out_valid) begin
            out_instr      = is32 ? {p1, p0} : {16'h0, p0};
            out_compressed = !is32;
        end

        accept    = in_valid && in_ready;
        handshake = out_valid && out_ready && !flush_i;
        skip      = skip_pending_q ? c_cnt_w'(flush_off_q) : '0;
        written   = accept ? (c_parcels_w - skip) : '0;
        consumed  = handshake ? (is32 ? c_cnt_w'(2) : c_cnt_w'(1)) : '0;

        if (flush_i) begin
            rd_ptr_d       = '0;
            wr_ptr_d       = '0;
            count_d        = '0;
            pc_d           = flush_pc_i;
            flush_off_d    = flush_off_in;
            skip_pending_d = 1'b1;
        end else begin
            if (accept) begin
                // Parcels below the redirect offset precede the target and are dropped.
                for (int i = 0; i < c_parcels; i++) begin
                    if (c_cnt_w'(i) >= skip) begin
                        mem_d[wr_ptr_q + c_ptr_w'(i) - c_ptr_w'(skip)] = in_data[16*i +: 16];
                    end
                end
                wr_ptr_d       = wr_ptr_q + c_ptr_w'(written);
                skip_pending_d = 1'b0;
            end
            if (handshake) begin
                rd_ptr_d = rd_ptr_q + c_ptr_w'(consumed);
                pc_d     = pc_q + (is32 ? ADDR_W'(4) : ADDR_W'(2));
            end
            count_d = count_q + written - consumed;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q          <= '{default: '0};
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            pc_q           <= RESET_PC;
            flush_off_q    <= '0;
            skip_pending_q <= 1'b0;
        end else begin
            mem_q          <= mem_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
            pc_q           <= pc_d;
            flush_off_q    <= flush_off_d;
            skip_pending_q <= skip_pending_d;
        end
    end

`ifdef FETCH_ALIGN_STATS_EN
    logic [31:0] rvc_cnt_q, rvc_cnt_d, rvi_cnt_q, rvi_cnt_d, stall_cnt_q, stall_cnt_d;

    // Saturating counters; deliberately untouched by flush.
    always_comb begin
        rvc_cnt_d   = rvc_cnt_q;
        rvi_cnt_d   = rvi_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (handshake && !is32 && (rvc_cnt_q != '1)) rvc_cnt_d = rvc_cnt_q + 32'd1;
        if (handshake && is32 && (rvi_cnt_q != '1))  rvi_cnt_d = rvi_cnt_q + 32'd1;
        if (out_ready && !out_valid && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rvc_cnt_q   <= '0;
            rvi_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            rvc_cnt_q   <= rvc_cnt_d;
            rvi_cnt_q   <= rvi_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stat_rvc_cnt   = rvc_cnt_q;
    assign stat_rvi_cnt   = rvi_cnt_q;
    assign stat_stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: doc/fetch_align_buffer.md
Name: fetch_align_buffer

Overview:
Parametrised parcel-based realignment buffer between instruction memory and decode. Accepts FETCH_W-bit fetch words, stores them as 16-bit parcels in a circular buffer, and emits one aligned instruction per handshake: a 32-bit instruction or a zero-extended 16-bit RVC instruction.
Handles instructions that straddle fetch-word boundaries, misaligned redirect targets, and back-pressure from decode. Sits between the fetch and decode stages as the successor of the single-word fetch-2 stage.

Parameters:
FETCH_W, 32, fetch word width in bits; multiple of 16; PARCELS = FETCH_W/16
DEPTH, 8, buffer capacity in 16-bit parcels; power of two; at least 2*PARCELS
ADDR_W, 32, PC width
RESET_PC, 0, out_pc value after reset

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
flush_i  in  1  redirect; discard buffer contents
flush_pc_i  in  ADDR_W  redirect target, bit 0 = 0
in_valid  in  1  fetch word valid
in_ready  out  1  buffer can accept a fetch word
in_data  in  FETCH_W  fetch word; parcel 0 = bits [15:0]
out_valid  out  1  aligned instruction available
out_ready  in  1  decode accepts instruction
out_instr  out  32  instruction; RVC zero-extended in [15:0]
out_pc  out  ADDR_W  PC of out_instr
out_compressed  out  1  out_instr is a 16-bit RVC instruction

Behaviour:
- Reset is asynchronous, active-low, on reset_n; clock is clk.
- Reset values: rd_ptr = wr_ptr = count = 0; skip_pending = 0; out_pc = RESET_PC. Resulting outputs: out_valid = 0, in_ready = 1, out_instr = 0, out_compressed = 0.
- Storage: DEPTH x 16-bit parcel RAM (flops). Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- in_ready = !flush_i && (DEPTH - count >= PARCELS). A fetch word is accepted when in_valid && in_ready.
- On accept, write parcels skip..PARCELS-1 at wr_ptr onward, then advance wr_ptr and count by PARCELS-skip.
  - skip = flush_pc_q[log2(FETCH_W/8)-1:1] when skip_pending, else 0.
  - skip_pending clears on the first accept after a flush.
- Head decode is combinational from the buffer:
  - p0 = parcel[rd_ptr], p1 = parcel[rd_ptr+1].
  - p0[1:0] == 2'b11: 32-bit instruction; out_valid = count >= 2; out_instr = {p1, p0}; out_compressed = 0.
  - Otherwise: out_valid = count >= 1; out_instr = {16'h0, p0}; out_compressed = 1.
  - While out_valid = 0, out_instr and out_compressed are 0.
- On handshake (out_valid && out_ready), rd_ptr and count advance by 1 (RVC) or 2 (32-bit), and out_pc advances by 2 or 4, wrapping at ADDR_W.
- Simultaneous write and read in one cycle: count_next = count + written - consumed. A full buffer with a simultaneous read still deasserts in_ready; in_ready is based on current count only.
- Latency: a word accepted in cycle N can appear at the output in cycle N+1. No bypass path from in_data to out_instr.
- Straddle: a 32-bit instruction whose upper parcel is not yet written holds out_valid = 0. Its lower parcel is retained, never dropped.
- Flush has highest priority. In the flush cycle:
  - in_ready = 0, and no read is performed.
  - Next state: count = 0, pointers = 0, out_pc = flush_pc_i, flush_pc_q = flush_pc_i, skip_pending = 1.
  - A second flush before any accept overrides the pending target.
- out_valid must stay stable while out_ready is low, except across a flush.
- Reset mid-operation: all state returns to reset values immediately (asynchronous).

Optional Feature:
FETCH_ALIGN_STATS_EN
- Defined: adds output ports stat_rvc_cnt[31:0], stat_rvi_cnt[31:0] and stat_stall_cnt[31:0].
  - stat_rvc_cnt / stat_rvi_cnt: count handshaken RVC / 32-bit instructions.
  - stat_stall_cnt: counts cycles with out_ready = 1 and out_valid = 0.
  - All three reset to 0, saturate at 32'hFFFFFFFF, and are unaffected by flush.
- Undefined: ports and counters absent; functional behaviour identical.

Test Plan:
- Reset, then words 32'h0001_4501 and 32'h4581_0505, out_ready = 1 -> RVC 16'h4501 @0, 16'h0001 @2, 16'h0505 @4, 16'h4581 @6; out_compressed = 1 each.
- Straddle: words 32'h0093_4501, then 32'h0000_0010 -> 16'h4501 @0; out_valid stays 0 until the second word is accepted; then 32'h0010_0093 @2 with out_compressed = 0.
- Flush to 32'h0000_0102, then word 32'h0513_1111 -> parcel 16'h1111 skipped; next word 32'h0000_0000 -> out_instr 32'h0000_0513 @0x102.
- Back-pressure: out_ready = 0, feed four RVC words with DEPTH = 8 -> in_ready = 0 after the fourth accept; count = 8; no data lost after releasing out_ready.
- Flush in the same cycle as in_valid and out_ready -> word not accepted, no handshake, out_valid = 0 next cycle, out_pc = flush_pc_i.
- FETCH_ALIGN_STATS_EN defined, run the first scenario -> stat_rvc_cnt = 4, stat_rvi_cnt = 0.
